// File: rtl/barrel_rotate_amount_finder.sv
// barrel_rotate_amount_finder
//   Sequential inverse of the rotate stages. Given an original word `a`, a
//   rotated word `y` and a direction, it recovers the smallest rotation amount
//   that maps `a` onto `y`. One candidate amount is tested per clock.
//
// Ports
//   clk    : system clock, all state updates on the rising edge
//   reset  : synchronous, active-high reset
//   start  : request a search, sampled only while ready=1
//   dir    : 0 = right rotate, 1 = left rotate
//   a      : original word, captured on an accepted start
//   y      : rotated word to match, captured on an accepted start
//   ready  : high in IDLE, the only state in which start is accepted
//   done   : one-cycle pulse when a search ends
//   found  : 1 = a matching amount exists
//   amt    : recovered amount, valid when found=1, otherwise 0
//
// WIDTH must equal 2**AMT_W; other combinations are unsupported.
module barrel_rotate_amount_finder #(
  parameter int AMT_W = 3,
  parameter int WIDTH = 2**AMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] y,
  output logic             ready,
  output logic             done,
  output logic             found,
  output logic [AMT_W-1:0] amt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Last candidate amount; the counter stops here instead of wrapping.
  localparam logic [AMT_W-1:0] K_LAST = AMT_W'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] y_r;
  logic             dir_r;
  logic [AMT_W-1:0] k_r;
  logic             ready_r;
  logic             done_r;
  logic             found_r;
  logic [AMT_W-1:0] amt_r;

  // Rotate a word by one bit position in the requested direction.
  function automatic logic [WIDTH-1:0] rot1(input logic [WIDTH-1:0] w,
                                            input logic             left);
    logic [WIDTH-1:0] r;
    if (left) begin
      r = {w[WIDTH-2:0], w[WIDTH-1]};
    end else begin
      r = {w[0], w[WIDTH-1:1]};
    end
    return r;
  endfunction

  // Search FSM: capture on start, test one amount per cycle, pulse done.
  // work_r always holds `a` rotated by k_r in dir_r, so a match at work_r
  // means k_r is the smallest amount (smaller ones were already rejected).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      work_r  <= {WIDTH{1'b0}};
      y_r     <= {WIDTH{1'b0}};
      dir_r   <= 1'b0;
      k_r     <= {AMT_W{1'b0}};
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      found_r <= 1'b0;
      amt_r   <= {AMT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            work_r  <= a;
            y_r     <= y;
            dir_r   <= dir;
            k_r     <= {AMT_W{1'b0}};
            found_r <= 1'b0;
            amt_r   <= {AMT_W{1'b0}};
            ready_r <= 1'b0;
            state_r <= ST_SEARCH;
          end else begin
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        ST_SEARCH: begin
          ready_r <= 1'b0;
          if (work_r == y_r) begin
            amt_r   <= k_r;
            found_r <= 1'b1;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else if (k_r == K_LAST) begin
            amt_r   <= {AMT_W{1'b0}};
            found_r <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            work_r  <= rot1(work_r, dir_r);
            k_r     <= k_r + AMT_W'(1);
            done_r  <= 1'b0;
            state_r <= ST_SEARCH;
          end
        end
        ST_DONE: begin
          // Leave unconditionally; start here is ignored, so the earliest
          // new accept is in the following IDLE cycle.
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_r;
  assign done  = done_r;
  assign found = found_r;
  assign amt   = amt_r;

endmodule

// File: tb/tb_barrel_rotate_amount_finder.sv
module tb_barrel_rotate_amount_finder;

  logic       clk;
  logic       reset;
  logic       start;
  logic       dir;
  logic [7:0] a;
  logic [7:0] y;
  logic       ready;
  logic       done;
  logic       found;
  logic [2:0] amt;

  int total;
  int bad;

  barrel_rotate_amount_finder #(.AMT_W(3), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .dir   (dir),
    .a     (a),
    .y     (y),
    .ready (ready),
    .done  (done),
    .found (found),
    .amt   (amt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dir;
    logic [7:0] a;
    logic [7:0] y;
    logic       found;
    logic [2:0] amt;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start a search and measure cycles from the start cycle T to the done cycle.
  task automatic run_search(input logic d, input logic [7:0] av,
                            input logic [7:0] yv, output int lat);
    @(negedge clk);
    chk("ready_before_start", int'(ready), 1);
    start = 1'b1; dir = d; a = av; y = yv;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; dir = 1'b0; a = 8'h00; y = 8'h00;

    vecs[0] = '{1'b0, 8'h96, 8'hD2, 1'b1, 3'd3, 5};
    vecs[1] = '{1'b1, 8'h81, 8'h03, 1'b1, 3'd1, 3};
    vecs[2] = '{1'b1, 8'h96, 8'h69, 1'b1, 3'd4, 6};
    vecs[3] = '{1'b0, 8'h55, 8'hAA, 1'b1, 3'd1, 3};
    vecs[4] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 3'd0, 2};
    vecs[5] = '{1'b0, 8'h01, 8'h03, 1'b0, 3'd0, 9};
    vecs[6] = '{1'b0, 8'h80, 8'h01, 1'b1, 3'd7, 9};
    vecs[7] = '{1'b1, 8'h80, 8'h01, 1'b1, 3'd1, 3};
    vecs[8] = '{1'b1, 8'h3C, 8'h3C, 1'b1, 3'd0, 2};
    vecs[9] = '{1'b1, 8'h00, 8'h00, 1'b1, 3'd0, 2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_done",  int'(done),  0);
    chk("rst_found", int'(found), 0);
    chk("rst_amt",   int'(amt),   0);
    reset = 1'b0;

    // Table-driven searches.
    for (int i = 0; i < 10; i++) begin
      run_search(vecs[i].dir, vecs[i].a, vecs[i].y, lat);
      chk($sformatf("v%0d_lat", i),   lat,              vecs[i].lat);
      chk($sformatf("v%0d_found", i), int'(found),      int'(vecs[i].found));
      chk($sformatf("v%0d_amt", i),   int'(amt),        int'(vecs[i].amt));
      chk($sformatf("v%0d_ready_in_done", i), int'(ready), 0);
      @(negedge clk);
      chk($sformatf("v%0d_one_pulse", i), int'(done),  0);
      chk($sformatf("v%0d_ready_after", i), int'(ready), 1);
      chk($sformatf("v%0d_found_hold", i), int'(found), int'(vecs[i].found));
      chk($sformatf("v%0d_amt_hold", i), int'(amt), int'(vecs[i].amt));
    end

    // Inputs and start disturbed during SEARCH must not affect the result.
    @(negedge clk);
    start = 1'b1; dir = 1'b0; a = 8'h96; y = 8'hD2;
    @(negedge clk);                       // T+1
    start = 1'b1; dir = 1'b1; a = 8'h11; y = 8'h22;
    @(negedge clk);                       // T+2
    start = 1'b0; a = 8'hFF; y = 8'hFF;
    @(negedge clk);                       // T+3
    start = 1'b1;
    @(negedge clk);                       // T+4
    start = 1'b0;
    chk("hs_done_early", int'(done), 0);
    @(negedge clk);                       // T+5
    chk("hs_done", int'(done), 1);
    chk("hs_found", int'(found), 1);
    chk("hs_amt", int'(amt), 3);
    // Start raised during DONE must be ignored; held into IDLE it is accepted.
    start = 1'b1; dir = 1'b0; a = 8'hFF; y = 8'hFF;
    @(negedge clk);                       // IDLE
    chk("done_start_ignored_ready", int'(ready), 1);
    chk("done_start_ignored_done", int'(done), 0);
    chk("done_start_ignored_amt", int'(amt), 3);
    @(negedge clk);                       // SEARCH after accept in IDLE
    start = 1'b0;
    chk("idle_start_accepted", int'(ready), 0);
    chk("idle_start_clears_amt", int'(amt), 0);
    @(negedge clk);
    chk("idle_start_done", int'(done), 1);
    chk("idle_start_found", int'(found), 1);
    chk("idle_start_amt", int'(amt), 0);

    // Reset in the middle of a no-match search aborts it silently.
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dir = 1'b0; a = 8'h01; y = 8'h03;
    @(negedge clk);                       // T+1
    start = 1'b0;
    repeat (3) @(negedge clk);            // T+4
    reset = 1'b1;
    @(negedge clk);                       // T+5
    reset = 1'b0;
    chk("abort_ready", int'(ready), 1);
    chk("abort_done",  int'(done),  0);
    chk("abort_found", int'(found), 0);
    chk("abort_amt",   int'(amt),   0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done_pulse", pulses, 0);
    chk("abort_idle_ready", int'(ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
